// File: rtl/counter_sched_pkg.sv
// Shared types for the interval-timer controller.
// No logic; state encoding only.
// No flow control.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/count_dp.sv
// WIDTH-bit up-counter with synchronous clear and enable, plus terminal compare.
// count registered, at_lim combinational from count and lim.
// No flow control; clr has priority over en.
module count_dp #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] count,
    output logic             at_lim
);

    // Counter register: clear wins, otherwise increment when enabled.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign at_lim = (count == lim);

endmodule

// File: rtl/counter_sched.sv
// Programmable interval timer: one-shot / periodic with start, stop, pause.
// All outputs registered; tc arrives limit+1 unpaused cycles after the start edge.
// No flow control; stop beats start beats pause on every edge.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   lim_q;
    logic               per_q;
    logic               at_lim;
    logic               clr;
    logic               en;
    logic               latch;
    logic               busy_d;
    logic               tc_d;
    logic               done_d;

    // The datapath has no reset of its own; reset is folded into its clear.
    count_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .clr    (clr | ~reset),
        .en     (en),
        .lim    (lim_q),
        .count  (count),
        .at_lim (at_lim)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!stop && start) state_nxt = RUN;
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (!pause && at_lim && !per_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath controls and next values of the output registers.
    always_comb begin
        clr    = 1'b0;
        en     = 1'b0;
        latch  = 1'b0;
        busy_d = 1'b0;
        tc_d   = 1'b0;
        done_d = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (!stop && start) begin
                    latch  = 1'b1;
                    busy_d = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    clr = 1'b1;
                end else if (pause) begin
                    busy_d = 1'b1;
                end else if (!at_lim) begin
                    en     = 1'b1;
                    busy_d = 1'b1;
                end else if (per_q) begin
                    // Explicit clear rather than wrap so any limit restarts at 0.
                    clr    = 1'b1;
                    busy_d = 1'b1;
                    tc_d   = 1'b1;
                end else begin
                    tc_d   = 1'b1;
                    done_d = 1'b1;
                end
            end
            DONE: begin
                if (stop) begin
                    clr = 1'b1;
                end else if (start) begin
                    clr    = 1'b1;
                    latch  = 1'b1;
                    busy_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: clr = 1'b1;
        endcase
    end

    // Output flags and the limit/mode latches captured at start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy  <= 1'b0;
            tc    <= 1'b0;
            done  <= 1'b0;
            lim_q <= '0;
            per_q <= 1'b0;
        end else begin
            busy <= busy_d;
            tc   <= tc_d;
            done <= done_d;
            if (latch) begin
                lim_q <= limit;
                per_q <= periodic;
            end
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// Testbench for counter_sched: table-driven vectors plus hand sequences.
// One vector per clock edge, outputs compared 1 time unit after the edge.
// No flow control on the DUT; expected values flow through a scoreboard queue.
module tb_counter_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       periodic;
    logic [3:0] limit;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       pause;
        logic       periodic;
        logic [3:0] limit;
        logic [3:0] x_count;
        logic       x_busy;
        logic       x_tc;
        logic       x_done;
    } vec_t;

    typedef struct {
        logic [3:0] count;
        logic       busy;
        logic       tc;
        logic       done;
        int         id;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    counter_sched #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .periodic (periodic),
        .limit    (limit),
        .count    (count),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int rst, int st, int sp, int pa, int pe, int lim,
                                int c, int b, int t, int d);
        vec_t v;
        v.rst      = rst[0];
        v.start    = st[0];
        v.stop     = sp[0];
        v.pause    = pa[0];
        v.periodic = pe[0];
        v.limit    = 4'(lim);
        v.x_count  = 4'(c);
        v.x_busy   = b[0];
        v.x_tc     = t[0];
        v.x_done   = d[0];
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, id, act, exp);
        end
    endtask

    // Drive one vector, push its expectation, clock once, pop and compare.
    task automatic cyc(input vec_t v, input int id);
        exp_t e;
        reset    = v.rst;
        start    = v.start;
        stop     = v.stop;
        pause    = v.pause;
        periodic = v.periodic;
        limit    = v.limit;
        e.count  = v.x_count;
        e.busy   = v.x_busy;
        e.tc     = v.x_tc;
        e.done   = v.x_done;
        e.id     = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", id);
        end else begin
            e = sb.pop_front();
            chk("count", e.id, 32'(count), 32'(e.count));
            chk("busy",  e.id, 32'(busy),  32'(e.busy));
            chk("tc",    e.id, 32'(tc),    32'(e.tc));
            chk("done",  e.id, 32'(done),  32'(e.done));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0; limit = 4'd0;

        //                rst st sp pa pe lim  cnt b  t  d
        // reset beats start
        tbl.push_back(mk(0, 1, 0, 0, 0, 5,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
        // one-shot limit=5; limit/mode change and start mid-run ignored
        tbl.push_back(mk(1, 1, 0, 0, 0, 5,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 9,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9,   2, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,   3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   4, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   5, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   5, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   5, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   5, 0, 0, 1));
        // limit=0 one-shot started from DONE
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 1));
        // limit=2 restart from DONE
        tbl.push_back(mk(1, 1, 0, 0, 0, 2,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2,   2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2,   2, 0, 1, 1));
        // stop from DONE
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,   0, 0, 0, 0));
        // pause: one-shot limit=3, held 3 edges at count=1
        tbl.push_back(mk(1, 1, 0, 0, 0, 3,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 3,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 3,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 3,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3,   2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3,   3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3,   3, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 3,   0, 0, 0, 0));
        // stop on the terminal edge: no tc
        tbl.push_back(mk(1, 1, 0, 0, 0, 4,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4,   1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4,   2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4,   3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4,   4, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4,   0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4,   0, 0, 0, 0));
        // periodic limit=0: tc every cycle after the first
        tbl.push_back(mk(1, 1, 0, 0, 1, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,   0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,   0, 1, 1, 0));
        // stop beats start, in RUN and in IDLE
        tbl.push_back(mk(1, 1, 1, 0, 1, 0,   0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 5,   0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i], i);
        end

        // Periodic limit=15 for 40 edges: wrap 15->0, tc on edges 16 and 32, start at 20 ignored.
        for (int k = 0; k < 40; k++) begin
            cyc(mk(1, (k == 0 || k == 20) ? 1 : 0, 0, 0, 1, 15,
                   k % 16, 1, (k > 0 && k % 16 == 0) ? 1 : 0, 0), 100 + k);
        end
        cyc(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 140);

        // Reset mid-run: periodic limit=9, reset for 2 edges at count=6, then quiet.
        for (int k = 0; k <= 6; k++) begin
            cyc(mk(1, (k == 0) ? 1 : 0, 0, 0, 1, 9, k, 1, 0, 0), 200 + k);
        end
        cyc(mk(0, 0, 0, 0, 1, 9, 0, 0, 0, 0), 207);
        cyc(mk(0, 0, 0, 0, 1, 9, 0, 0, 0, 0), 208);
        for (int k = 0; k < 3; k++) begin
            cyc(mk(1, 0, 0, 0, 1, 9, 0, 0, 0, 0), 209 + k);
        end
        // Fresh one-shot limit=1 after reset.
        cyc(mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 0), 212);
        cyc(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0), 213);
        cyc(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 1), 214);
        cyc(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 1), 215);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
